serial_add_seq: RTL and testbench

Operand sequencer and result collector for the 4-bit serial adder stage. It accepts two parallel operands over a valid/ready handshake and streams them LSB-first onto the adder's `s_in` with `shift_ctrl` held high. It then runs the adder for `WIDTH` more shift cycles, deserialises the adder's `s_out` into a parallel result, and offers that result over a second valid/ready handshake. It sits directly upstream of the serial adder, driving its inputs, and directly downstream of it, consuming its output.

---
 rtl/serial_add_seq.sv | 84 ++++++++
 tb/tb_serial_add_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq: operand streamer and result deserialiser around a serial adder.
// Define SERIAL_ADD_SEQ_CLEAR_EN to add the active-low adder_clear_b pulse after each acceptance.
module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             s_in,
    output logic             shift_ctrl,
    input  logic             s_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADD_SEQ_CLEAR_EN
    output logic             adder_clear_b,
`endif
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2:0] IDLE = 3'd0, SHIFT_A = 3'd1, SHIFT_B = 3'd2, RUN = 3'd3, DONE = 3'd4;
`ifdef SERIAL_ADD_SEQ_CLEAR_EN
    localparam logic [2:0] CLEAR = 3'd5;
    localparam logic [2:0] FIRST = CLEAR;
`else
    localparam logic [2:0] FIRST = SHIFT_A;
`endif

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg, b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= op_a;
                    b_reg <= op_b;
                    state <= FIRST;
                end
`ifdef SERIAL_ADD_SEQ_CLEAR_EN
                CLEAR: state <= SHIFT_A;
`endif
                SHIFT_A: begin
                    a_reg <= a_reg >> 1;
                    cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) state <= SHIFT_B;
                end
                SHIFT_B: begin
                    b_reg <= b_reg >> 1;
                    cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) state <= RUN;
                end
                RUN: begin
                    result <= {s_out, result[WIDTH-1:1]};
                    cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; in_ready also masks rst.
    assign busy       = (state != IDLE);
    assign in_ready   = (state == IDLE) && !rst;
    assign out_valid  = (state == DONE);
    assign shift_ctrl = (state == SHIFT_A) || (state == SHIFT_B) || (state == RUN);
    assign s_in       = (state == SHIFT_A) ? a_reg[0] : ((state == SHIFT_B) && b_reg[0]);
`ifdef SERIAL_ADD_SEQ_CLEAR_EN
    assign adder_clear_b = (state != CLEAR);
`endif
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: scoreboard bench for serial_add_seq (WIDTH=4), optional SERIAL_ADD_SEQ_CLEAR_EN.
module tb_serial_add_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         s_in, shift_ctrl;
    logic         s_out = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         busy;
`ifdef SERIAL_ADD_SEQ_CLEAR_EN
    logic         adder_clear_b;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] sb[$];

    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .s_in(s_in), .shift_ctrl(shift_ctrl),
        .s_out(s_out), .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
`ifdef SERIAL_ADD_SEQ_CLEAR_EN
        .adder_clear_b(adder_clear_b),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] sbits,
                          input int hold, input int rst_at, input bit poke);
        logic [2*W-1:0] stream;
        logic [W-1:0]   exp;
        stream = {b, a};
        check("in_ready_idle", in_ready, 1);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        sb.push_back(sbits);
        step();
        in_valid = 1'b0;
        op_a = ~a;
        op_b = ~b;
`ifdef SERIAL_ADD_SEQ_CLEAR_EN
        check("clear_low", adder_clear_b, 0);
        check("clear_sc", shift_ctrl, 0);
        check("clear_busy", busy, 1);
        step();
        check("clear_high", adder_clear_b, 1);
`endif
        for (int i = 0; i < 2 * W; i++) begin
            check("sc_shift", shift_ctrl, 1);
            check("s_in", s_in, stream[i]);
            check("ov_shift", out_valid, 0);
            if (poke && i == W + 1) begin
                check("rdy_busy", in_ready, 0);
                in_valid = 1'b1;
                op_a = W'($urandom);
                op_b = W'($urandom);
            end
            step();
            in_valid = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
            check("sc_run", shift_ctrl, 1);
            check("s_in_run", s_in, 0);
            s_out = sbits[i];
            if (i == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                s_out = 1'b0;
                #1;
                check("rst_sc", shift_ctrl, 0);
                check("rst_res", result, 0);
                check("rst_busy", busy, 0);
                check("rst_rdy", in_ready, 1);
                void'(sb.pop_back());
                return;
            end
            step();
        end
        s_out = 1'b0;
        check("ov_done", out_valid, 1);
        check("sc_done", shift_ctrl, 0);
        exp = sb.pop_front();
        check("result", result, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            check("ov_hold", out_valid, 1);
            check("res_hold", result, exp);
            check("rdy_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ov_idle", out_valid, 0);
        check("busy_idle", busy, 0);
        check("res_keep", result, exp);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        check("rst_rdy", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_sc", shift_ctrl, 0);
        check("rst_sin", s_in, 0);
        check("rst_ov", out_valid, 0);
        check("rst_res", result, 0);
`ifdef SERIAL_ADD_SEQ_CLEAR_EN
        check("rst_clr", adder_clear_b, 1);
`endif
        rst = 1'b0;
        #1;
        // Directed stream/capture with backpressure, then busy rejection, back-to-back.
        run_op(4'b1010, 4'b0011, 4'b1101, 5, -1, 1'b0);
        run_op(4'b0110, 4'b1001, 4'b0110, 0, -1, 1'b1);
        run_op(4'b1111, 4'b0001, 4'b1000, 1, -1, 1'b0);
        run_op(4'b0101, 4'b1100, 4'b1011, 0, 2, 1'b0);
        run_op(4'b0011, 4'b0101, 4'b0111, 2, -1, 1'b1);
        for (int k = 0; k < 6; k++)
            run_op(W'($urandom), W'($urandom), W'($urandom), k % 3, -1, k[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
